// File: rtl/pc_unit.sv
// Program counter with hardware return-address stack. Executes inc/jmp/call/ret (ret > call > jmp > inc).
// Latency: one cycle from command to pc. Backpressure: none; commands are always accepted.
// Build option PC_STACK_GUARD_EN: a call on a full stack or a ret on an empty stack sets stack_err and halts until rst.
module pc_unit #(
    parameter int              AW        = 8,
    parameter int              DEPTH     = 8,
    parameter logic [AW-1:0]   RESET_VEC = '0,
    parameter int              RET_OFS   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         inc,
    input  logic                         jmp,
    input  logic                         call,
    input  logic                         ret,
    input  logic [AW-1:0]                instaddr,
    output logic [AW-1:0]                pc,
    output logic [$clog2(DEPTH+1)-1:0]   sp,
    output logic                         stack_full,
    output logic                         stack_empty,
    output logic                         stack_err
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam int WPW = $clog2(DEPTH);

    localparam logic [AW-1:0]  RET_INC = AW'(RET_OFS);
    localparam logic [AW-1:0]  PC_ONE  = AW'(1);
    localparam logic [SPW-1:0] SP_MAX  = SPW'(DEPTH);
    localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
    localparam logic [WPW-1:0] WP_ONE  = WPW'(1);

`ifdef PC_STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    typedef enum logic {RUN, HALT} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [SPW-1:0]  sp_q, sp_d;
    logic [WPW-1:0]  wp_q, wp_d, wp_dec;
    logic            err_q, err_d;
    logic            push;
    logic [AW-1:0]   push_dat;
    logic [AW-1:0]   stack_q [DEPTH];
    logic            full, empty;

    assign full   = (sp_q == SP_MAX);
    assign empty  = (sp_q == '0);
    assign wp_dec = wp_q - WP_ONE;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        sp_d     = sp_q;
        wp_d     = wp_q;
        err_d    = err_q;
        push     = 1'b0;
        push_dat = pc_q + RET_INC;
        if (state_q == RUN) begin
            if (ret) begin
                if (GUARD && empty) begin
                    err_d   = 1'b1;
                    state_d = HALT;
                end else begin
                    wp_d = wp_dec;
                    pc_d = stack_q[wp_dec];
                    sp_d = empty ? sp_q : sp_q - SP_ONE;
                end
            end else if (call) begin
                if (GUARD && full) begin
                    err_d   = 1'b1;
                    state_d = HALT;
                end else begin
                    // Unguarded overflow overwrites the oldest entry; sp saturates.
                    push = 1'b1;
                    wp_d = wp_q + WP_ONE;
                    pc_d = instaddr;
                    sp_d = full ? sp_q : sp_q + SP_ONE;
                end
            end else if (jmp) begin
                pc_d = instaddr;
            end else if (inc) begin
                pc_d = pc_q + PC_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_VEC;
            sp_q    <= '0;
            wp_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            wp_q    <= wp_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else if (push) begin
            stack_q[wp_q] <= push_dat;
        end
    end

    assign pc          = pc_q;
    assign sp          = sp_q;
    assign stack_full  = full;
    assign stack_empty = empty;
    assign stack_err   = err_q;

endmodule
